// File: rtl/uart_alu_ctrl_pkg.sv
// Shared types for the UART/ALU frame sequencer: FSM state encoding, the
// accepted opcode constants and the opcode-valid check.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    COMPUTE = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  function automatic logic op_valid(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of UART, ALU and status signals around the frame sequencer.
// master = sequencer side, slave = UART/ALU/environment side.
interface uart_alu_ctrl_if #(
  parameter int N_BITS = 8,
  parameter int N_OP   = 6
);
  import uart_alu_pkg::*;

  // Handshake: rx_done, tx_done, tx_start, op_err and rx_drop are single-cycle
  // pulses sampled on the rising clk edge; rx_data is valid only with rx_done,
  // tx_data is held from tx_start until the matching tx_done.
  logic [N_BITS-1:0] rx_data;
  logic              rx_done;
  logic              tx_done;
  logic [N_BITS-1:0] alu_result;
  logic [N_BITS-1:0] alu_a;
  logic [N_BITS-1:0] alu_b;
  logic [N_OP-1:0]   alu_op;
  logic [N_BITS-1:0] tx_data;
  logic              tx_start;
  logic              busy;
  logic              op_err;
  logic              rx_drop;
  state_t            dbg_state;

  modport master (
    input  rx_data, rx_done, tx_done, alu_result,
    output alu_a, alu_b, alu_op, tx_data, tx_start, busy, op_err, rx_drop, dbg_state
  );

  modport slave (
    output rx_data, rx_done, tx_done, alu_result,
    input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, op_err, rx_drop, dbg_state
  );

endinterface

// File: rtl/uart_alu_ctrl_frame_timer.sv
// Inter-byte timeout counter: counts while enabled, restarts on clear, and
// flags expiry after CYCLES-1 counts unless a clear arrives in the same cycle.
module frame_timer #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LIMIT = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && !clear_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear_i || !en_i || expired_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between UART and combinational ALU: collects A, B, opcode,
// launches one transmission of the result. Optional timeout: UART_ALU_TIMEOUT_EN.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int N_BITS         = 8,
  parameter int N_OP           = 6,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input logic             clk,
  input logic             reset,
  uart_alu_ctrl_if.master bus
);

  state_t            state_q, state_d;
  logic [N_BITS-1:0] alu_a_q, alu_a_d;
  logic [N_BITS-1:0] alu_b_q, alu_b_d;
  logic [N_OP-1:0]   alu_op_q, alu_op_d;
  logic [N_BITS-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              op_err_q, op_err_d;
  logic              rx_drop_q, rx_drop_d;
  logic              expired;
  logic              op_ok;

`ifdef UART_ALU_TIMEOUT_EN
  frame_timer #(.CYCLES(TIMEOUT_CYCLES)) u_frame_timer (
    .clk       (clk),
    .rst       (reset),
    .clear_i   (bus.rx_done),
    .en_i      ((state_q == WAIT_B) || (state_q == WAIT_OP)),
    .expired_o (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired        = 1'b0;
`endif

  assign op_ok = op_valid(bus.rx_data[N_OP-1:0]) && (bus.rx_data[N_BITS-1:N_OP] == '0);

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    op_err_d   = 1'b0;
    rx_drop_d  = 1'b0;
    case (state_q)
      WAIT_A: if (bus.rx_done) begin
        alu_a_d = bus.rx_data;
        state_d = WAIT_B;
      end
      WAIT_B: if (bus.rx_done) begin
        alu_b_d = bus.rx_data;
        state_d = WAIT_OP;
      end else if (expired) begin
        op_err_d = 1'b1;
        state_d  = WAIT_A;
      end
      WAIT_OP: if (bus.rx_done) begin
        if (op_ok) begin
          alu_op_d = bus.rx_data[N_OP-1:0];
          state_d  = COMPUTE;
        end else begin
          op_err_d = 1'b1;
          state_d  = WAIT_A;
        end
      end else if (expired) begin
        op_err_d = 1'b1;
        state_d  = WAIT_A;
      end
      // tx_start is registered, so it is raised on entry to SEND.
      COMPUTE: begin
        tx_data_d  = bus.alu_result;
        tx_start_d = 1'b1;
        rx_drop_d  = bus.rx_done;
        state_d    = SEND;
      end
      SEND: begin
        rx_drop_d = bus.rx_done;
        state_d   = WAIT_TX;
      end
      WAIT_TX: begin
        rx_drop_d = bus.rx_done;
        if (bus.tx_done) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      op_err_q   <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      op_err_q   <= op_err_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.op_err    = op_err_q;
  assign bus.rx_drop   = rx_drop_q;
  assign bus.busy      = (state_q != WAIT_A);
  assign bus.dbg_state = state_q;

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Frame sequencer between the UART (RX/TX) and the combinational ALU.
- Collects three received bytes in order: operand A, operand B, opcode. Drives the ALU, captures its result and launches one UART transmission of the result.
- Rejects invalid opcodes and serialises frames: one frame in flight at a time.

Parameters:
- N_BITS, 8, data/operand width; equals UART byte width.
- N_OP, 6, opcode width; low N_OP bits of the opcode byte.
- TIMEOUT_CYCLES, 500000, inter-byte timeout in clk cycles; used only with UART_ALU_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  N_BITS  received byte; valid when rx_done=1.
- rx_done  in  1  one-cycle pulse, byte received.
- tx_done  in  1  one-cycle pulse, UART transmission finished.
- alu_result  in  N_BITS  combinational ALU output.
- alu_a  out  N_BITS  operand A register.
- alu_b  out  N_BITS  operand B register.
- alu_op  out  N_OP  opcode register.
- tx_data  out  N_BITS  byte to transmit; stable from tx_start until tx_done.
- tx_start  out  1  one-cycle pulse, start transmission.
- busy  out  1  high in every state except WAIT_A.
- op_err  out  1  one-cycle pulse, invalid opcode; frame dropped.
- rx_drop  out  1  one-cycle pulse, byte arrived during COMPUTE/SEND/WAIT_TX and was discarded.

Behaviour:
- Reset (async, active-high): state=WAIT_A; alu_a, alu_b, alu_op, tx_data = 0; tx_start, op_err, rx_drop = 0; timer = 0.
- All outputs are registered. Every transition occurs on a rising clk edge.
- WAIT_A: on rx_done, alu_a<=rx_data, go to WAIT_B.
- WAIT_B: on rx_done, alu_b<=rx_data, go to WAIT_OP.
- WAIT_OP: on rx_done:
  - rx_data[N_OP-1:0] is in the valid set and rx_data[N_BITS-1:N_OP]==0: alu_op<=rx_data[N_OP-1:0], go to COMPUTE.
  - Otherwise: op_err=1 for one cycle, go to WAIT_A. alu_a, alu_b and alu_op keep their old values.
- COMPUTE: exactly one cycle, letting the ALU settle; tx_data<=alu_result, go to SEND.
- SEND: tx_start=1 for this one cycle, go to WAIT_TX.
- WAIT_TX: on tx_done, go to WAIT_A.
- Latency: rx_done of the opcode byte at edge k gives tx_start high during cycle k+2.
- rx_done in COMPUTE/SEND/WAIT_TX: byte ignored, rx_drop pulses next cycle, state unaffected.
- rx_done and tx_done in the same cycle in WAIT_TX: go to WAIT_A; the byte is dropped (rx_drop=1), not taken as operand A.
- tx_done outside WAIT_TX is ignored.
- Reset mid-frame: immediate return to WAIT_A with all registers cleared. A transmission already started in the UART is not aborted by this block.
- Valid opcode set (6-bit): ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.

Optional Feature:
- Macro: UART_ALU_TIMEOUT_EN.
- Defined:
  - A counter clears on every rx_done and increments each cycle in WAIT_B or WAIT_OP.
  - When it reaches TIMEOUT_CYCLES-1 without rx_done, the state returns to WAIT_A and op_err pulses once, same as a rejected frame.
  - rx_done in the same cycle as expiry wins: the byte is accepted, no timeout.
  - The counter is held at 0 in all other states.
- Not defined: no counter logic; WAIT_B/WAIT_OP wait indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package uart_alu_pkg holds:
  - the state encoding (WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX; 3 bits);
  - the eight opcode constants;
  - the opcode-valid function.
- One natural sub-module, frame_timer: the timeout counter (clear/enable inputs, expired output). It is instantiated only under UART_ALU_TIMEOUT_EN.

Test Plan:
- Bytes 0x05, 0x03, 0x20 with a bench ALU model:
  - alu_a=0x05, alu_b=0x03, alu_op=6'h20;
  - tx_start pulses 2 cycles after the third rx_done, with tx_data=0x08;
  - busy falls the cycle after tx_done.
- Bytes 0x0A, 0x0F, 0x3F: op_err pulses once, no tx_start, state WAIT_A. Then 0xF0, 0x04, 0x03 gives tx_data=0xFF (SRA of 0xF0 by 4).
- Extra rx_done (0x77) while in WAIT_TX: rx_drop pulses, tx_data unchanged. A following 0x01, 0x01, 0x22 frame gives tx_data=0x00.
- Assert reset while in WAIT_OP: all outputs 0 in the same cycle (async). The next frame 0x02, 0x02, 0x24 gives tx_data=0x02.
- Under UART_ALU_TIMEOUT_EN with TIMEOUT_CYCLES=100:
  - send 0x05, then no byte for 100 cycles: op_err pulses, state WAIT_A;
  - rx_done on the expiry cycle is accepted as operand B.
